mp_add_ctrl: RTL and testbench
==============================

MP_ADD_CTRL -- requirements
Module: mp_add_ctrl

Interface
REQ-001 Parameter SLICE, default 9: width of the single shared adder slice, in bits.
REQ-002 Parameter NBEATS, default 4: number of slices per operation; operand width W = SLICE*NBEATS (36 at defaults).
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: request to begin an addition; sampled only in IDLE.
REQ-006 Port a, input, W: operand A, captured on accepted start.
REQ-007 Port b, input, W: operand B, captured on accepted start.
REQ-008 Port cin, input, 1: carry-in to slice 0, captured on accepted start.
REQ-009 Port busy, output, 1: high when state is not IDLE.
REQ-010 Port done, output, 1: one-cycle completion pulse.
REQ-011 Port sum, output, W: registered result A+B+cin modulo 2^W.
REQ-012 Port cout, output, 1: registered carry-out of the top slice.
REQ-013 Port ovf, output, 1: registered two's-complement overflow of the full-width add.

Function
REQ-014 The block SHALL contain exactly one SLICE-bit adder with carry-in, reused on every beat; no W-bit adder is permitted.
REQ-015 The FSM SHALL have states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 at an edge captures a, b and cin into internal registers, clears the beat counter to 0, and moves to RUN; start=0 remains in IDLE.
REQ-017 RUN: each edge SHALL add slice[beat] of A and B with the carry register, write the SLICE-bit result into sum slice[beat], update the carry register with the slice carry-out, and increment beat.
REQ-018 Slice 0 SHALL use the captured cin; slice k>0 SHALL use the carry from slice k-1.
REQ-019 On the edge processing beat NBEATS-1, the FSM SHALL move to DONE, load cout with the final carry, and load ovf = (A[W-1]==B[W-1]) AND (result[W-1]!=A[W-1]).
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle following the NBEATS-th edge after the start-accepting edge (4 edges at defaults).
REQ-022 start SHALL be ignored in RUN and DONE; operands changing during RUN SHALL not affect the result.
REQ-023 sum, cout and ovf SHALL hold their values from done until the next accepted start; partial sum slices SHALL be visible during RUN.
REQ-024 With start held high continuously, a new operation SHALL be accepted on the first IDLE edge, giving one idle cycle between done and the next RUN.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and clear busy, done, sum, cout, ovf, the carry register, the beat counter and the operand registers to 0.
REQ-026 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL never produce a done pulse.

Verification
REQ-027 a=36'h0_0000_01FF, b=1, cin=0 -> sum=36'h0_0000_0200, cout=0, ovf=0; done 4 edges after start edge; busy high for 5 cycles.
REQ-028 a=36'hF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0 (carry ripples through all 4 beats).
REQ-029 a=36'h7_FFFF_FFFF, b=1, cin=0 -> sum=36'h8_0000_0000, cout=0, ovf=1.
REQ-030 Start a=5, b=3; during beat 1 assert start with a=b=36'hF_0000_0000 -> result sum=8; the second request is not accepted.
REQ-031 rst asserted at beat 2 -> next cycle busy=0, sum=0, no done pulse; a subsequent start a=1, b=1 yields sum=2.
REQ-032 start held high over two operations -> done pulses exactly once per operation, with one IDLE cycle between DONE and the next RUN.

Source files
------------

// File: rtl/mp_add_ctrl.sv
// Multi-precision adder controller: one SLICE-bit adder reused over NBEATS beats
// to form a W-bit sum with registered carry-out and signed overflow.
module mp_add_ctrl #(
    parameter int SLICE  = 9,
    parameter int NBEATS = 4,
    localparam int W     = SLICE * NBEATS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    // Operands and result held as slice arrays so each beat indexes one slice directly.
    logic [NBEATS-1:0][SLICE-1:0] a_reg, b_reg, sum_reg;
    logic                         carry;
    logic [BW-1:0]                beat;
    logic [SLICE-1:0]             slice_sum;
    logic                         slice_cout;

    assign sum = sum_reg;

    always_comb begin
        {slice_cout, slice_sum} = {1'b0, a_reg[beat]} + {1'b0, b_reg[beat]} + {{SLICE{1'b0}}, carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (beat == LAST) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            beat    <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        beat  <= '0;
                    end
                end
                RUN: begin
                    sum_reg[beat] <= slice_sum;
                    carry         <= slice_cout;
                    beat          <= beat + 1'b1;
                    // Top slice: its fresh result bit is the sign of the full-width sum.
                    if (beat == LAST) begin
                        cout <= slice_cout;
                        ovf  <= (a_reg[NBEATS-1][SLICE-1] == b_reg[NBEATS-1][SLICE-1]) &&
                                (slice_sum[SLICE-1] != a_reg[NBEATS-1][SLICE-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Self-checking bench for mp_add_ctrl: vector table plus scoreboard of expected
// results, and hand sequences for ignored start, mid-run reset and back-to-back starts.
module tb_mp_add_ctrl;

    localparam int SLICE  = 9;
    localparam int NBEATS = 4;
    localparam int W      = SLICE * NBEATS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[7];

    mp_add_ctrl #(.SLICE(SLICE), .NBEATS(NBEATS)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        vec_t v;
        logic [W:0] full;
        full   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        v.a    = ta;
        v.b    = tb;
        v.cin  = tc;
        v.sum  = full[W-1:0];
        v.cout = full[W];
        v.ovf  = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
                check("ovf", 64'(ovf), 64'(e.ovf));
            end
        end
    end

    task automatic run_op(input vec_t v);
        int n = 0;
        int busy_cycles = 0;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin;
            end
            if (busy) busy_cycles++;
            if (done) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            check("done_timeout", 64'(done), 64'd1);
        end else begin
            check("latency", 64'(n - 1), 64'(NBEATS));
            check("busy_cycles", 64'(busy_cycles), 64'(NBEATS + 1));
        end
        @(negedge clk);
        check("hold_sum", 64'(sum), 64'(v.sum));
        check("hold_cout", 64'(cout), 64'(v.cout));
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t v;
        int n;
        int done_cnt;
        int first_done;
        int second_done;

        vecs[0] = '{36'h0_0000_01FF, 36'h0_0000_0001, 1'b0, 36'h0_0000_0200, 1'b0, 1'b0};
        vecs[1] = '{36'hF_FFFF_FFFF, 36'h0_0000_0000, 1'b1, 36'h0_0000_0000, 1'b1, 1'b0};
        vecs[2] = '{36'h7_FFFF_FFFF, 36'h0_0000_0001, 1'b0, 36'h8_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{36'h8_0000_0000, 36'h8_0000_0000, 1'b0, 36'h0_0000_0000, 1'b1, 1'b1};
        vecs[4] = '{36'h1_2345_6789, 36'h0_FEDC_BA98, 1'b0, 36'h2_2222_2221, 1'b0, 1'b0};
        vecs[5] = '{36'h0_0000_0000, 36'h0_0000_0000, 1'b1, 36'h0_0000_0001, 1'b0, 1'b0};
        vecs[6] = '{36'h0_0000_0005, 36'hF_FFFF_FFFB, 1'b0, 36'h0_0000_0000, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start", 64'(busy), 64'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            run_op(model(W'({$urandom, $urandom}), W'({$urandom, $urandom}), 1'($urandom)));
        end

        // Start during RUN with different operands must be ignored.
        v = model(36'd5, 36'd3, 1'b0);
        check("model_5_3", 64'(v.sum), 64'd8);
        @(negedge clk);
        a = v.a; b = v.b; cin = 1'b0; start = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 2) begin
                start = 1'b1; a = 36'hF_0000_0000; b = 36'hF_0000_0000;
            end
            if (done) begin
                n = i;
                start = 1'b0;
                break;
            end
        end
        check("ign_latency", 64'(n - 1), 64'(NBEATS));
        repeat (2) begin
            @(negedge clk);
            check("ign_not_accepted", 64'(busy), 64'd0);
        end

        // Reset at beat 2 aborts the operation without a done pulse.
        @(negedge clk);
        a = 36'h1_2345_6789; b = 36'h0_1111_1111; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_still_idle", 64'(busy), 64'd0);
        run_op(model(36'd1, 36'd1, 1'b0));

        // start held high: two operations with one idle cycle between them.
        @(negedge clk);
        v = model(36'h0_0000_00FF, 36'h0_0000_0101, 1'b0);
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        v = model(36'h5_5555_5555, 36'h2_AAAA_AAAB, 1'b0);
        a = v.a; b = v.b; cin = v.cin;
        sb.push_back(v);
        done_cnt = 0; first_done = 0; second_done = 0;
        for (int i = 2; i <= 30 && done_cnt < 2; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) first_done = i;
                else begin
                    second_done = i;
                    start = 1'b0;
                end
            end
            if (first_done != 0 && i == first_done + 1) check("b2b_idle_gap", 64'(busy), 64'd0);
            if (first_done != 0 && i == first_done + 2) check("b2b_restart", 64'(busy), 64'd1);
        end
        start = 1'b0;
        check("b2b_done_count", 64'(done_cnt), 64'd2);
        check("b2b_first_done", 64'(first_done), 64'(NBEATS + 1));
        check("b2b_second_done", 64'(second_done), 64'(2 * NBEATS + 3));
        repeat (2) begin
            @(negedge clk);
            check("b2b_final_idle", 64'(busy), 64'd0);
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
